alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder and returns the result over a valid/ready handshake. Single-cycle operations (ADD…SLTU) complete in one cycle. MUL (code 4'b1010) runs on an iterative shift-add multiplier. The unit sits in the EX stage, between operand select and the writeback/memory-address path.

## Interface
- `XLEN`, default 32, operand and result width; a power of two, minimum 8.
- `SHW`, default $clog2(XLEN), width of the shift amount taken from `src_b`.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands and code are valid.
- `in_ready`  output  1  unit accepts an operation this cycle.
- `alu_ctrl`  input  4  operation code.
- `src_a`  input  XLEN  operand A.
- `src_b`  input  XLEN  operand B; shift ops use `src_b[SHW-1:0]`.
- `out_valid`  output  1  `result`/`zero`/`illegal` are valid.
- `out_ready`  input  1  consumer takes the result this cycle.
- `result`  output  XLEN  registered result.
- `zero`  output  1  high when `result` == 0.
- `illegal`  output  1  high when the accepted code was unsupported.

## Operation
- **Codes:**
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU (unsigned): result is 1 or 0, zero-extended.
  - 1010 MUL: low XLEN bits of the product; sign of the operands does not matter.
  - 1011–1111: `result`=0, `zero`=1, `illegal`=1.
- **Arithmetic:** ADD/SUB wrap modulo 2^XLEN. SRA replicates `src_a[XLEN-1]`.
- **Acceptance:** an operation is accepted on a rising edge where `in_valid && in_ready`. Operands are captured at that edge; later changes on the inputs are ignored.
- **FSM states:**
  - IDLE: `in_ready = !out_valid || out_ready`.
  - MUL_BUSY: `in_ready`=0.
- **Transitions:**
  - IDLE to IDLE on accepting a non-MUL op: the output register loads at the accept edge.
  - IDLE to MUL_BUSY on accepting a MUL: the accumulator clears, the multiplicand loads `src_a`, the multiplier loads `src_b`, and the counter is set to 0.
  - In MUL_BUSY, each edge: if multiplier[0] is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; increment the counter.
  - MUL_BUSY to IDLE on the edge where the counter reaches XLEN-1: the output register loads the final accumulator and `out_valid` is set.
- **Output holding:** the output register holds while `out_valid && !out_ready`. `out_valid` clears on `out_valid && out_ready` unless a new result loads on the same edge.
- **Simultaneous events:** a consumer handshake and a new accept in the same IDLE cycle are legal. The new result replaces the old one and `out_valid` stays 1.
- **MUL_BUSY is entered only when the output is free:** `out_valid` is 0, or `out_ready` is high on the entry edge.

## Timing
- **Reset (asynchronous, `rst_n` low):**
  - State goes to IDLE; the counter, accumulator and operand registers go to 0.
  - `out_valid`=0, `result`=0, `zero`=1, `illegal`=0.
  - `in_ready`=1 once `rst_n` is high.
- **Reset during MUL_BUSY** aborts the operation. No result is ever produced for it.
- **Latency:**
  - Non-MUL ops: `out_valid` goes high at the accept edge, i.e. visible the cycle after `in_valid`.
  - MUL: `out_valid` goes high XLEN edges after the accept edge (32 for the default).
- **Throughput:**
  - One non-MUL op per cycle while `out_ready` stays high.
  - One MUL per XLEN+1 cycles.
- **Outputs:** `zero` and `illegal` are registered together with `result`. There is no combinational path from `alu_ctrl`/`src_*` to any output.
- **Backpressure:** `in_ready` depends combinationally on `out_ready`, and only in IDLE.

## Configuration
- **`ALU_MUL_EN` defined:** the iterative multiplier and the MUL_BUSY state are compiled in; code 1010 behaves as described above.
- **`ALU_MUL_EN` undefined:** there is no multiplier logic and no MUL_BUSY state. Code 1010 is treated as unsupported: one-cycle latency, `result`=0, `zero`=1, `illegal`=1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → `out_valid`=0, `result`=0, `zero`=1, `in_ready`=1 after release.
- **Back-to-back simple ops with `out_ready`=1:**
  - SUB 5-7 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - One result per cycle.
- **MUL 0xFFFFFFFF×3:**
  - With `ALU_MUL_EN`: `in_ready`=0 for 32 cycles, then `result`=0xFFFFFFFD with `out_valid`=1 exactly 32 edges after accept.
  - Without it: `illegal`=1 next cycle.
- **Backpressure:** ADD 2+2 with `out_ready`=0 for 3 cycles → `result`=4 held stable, `in_ready`=0. Raise `out_ready` → a new op is accepted in the same cycle.
- **Illegal code 1101** → `result`=0, `zero`=1, `illegal`=1. The next legal op (XOR 0xF0^0x0F=0xFF) clears `illegal`.
- **Reset pulse at counter=10 of MUL 6×7** → no `out_valid`. A fresh MUL 6×7 afterwards returns 42.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU with valid/ready handshake; define ALU_MUL_EN for the iterative shift-add MUL
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  logic [XLEN-1:0] alu_res, load_res;
  logic alu_ill, load, load_ill;
  logic [SHW-1:0] sh;
  assign sh = src_b[SHW-1:0];
  always_comb begin
    alu_ill = 1'b0;
    case (alu_ctrl)
      4'h0: alu_res = src_a + src_b;
      4'h1: alu_res = src_a - src_b;
      4'h2: alu_res = src_a & src_b;
      4'h3: alu_res = src_a | src_b;
      4'h4: alu_res = src_a ^ src_b;
      4'h5: alu_res = src_a << sh;
      4'h6: alu_res = src_a >> sh;
      4'h7: alu_res = $signed(src_a) >>> sh;
      4'h8: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'h9: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end
`ifdef ALU_MUL_EN
  localparam logic [3:0] MUL = 4'hA;
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state, state_nxt;
  logic [SHW-1:0] cnt;
  logic [XLEN-1:0] acc, mcand, mplier, acc_nxt;
  logic mul_start;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign mul_start = state == IDLE && in_valid && in_ready && alu_ctrl == MUL;
  always_comb begin
    state_nxt = state;
    in_ready = 1'b0;
    load = 1'b0;
    load_res = alu_res;
    load_ill = alu_ill;
    if (state == IDLE) begin
      in_ready = !out_valid || out_ready;
      load = in_valid && in_ready && alu_ctrl != MUL;
      state_nxt = mul_start ? MUL_BUSY : IDLE;
    end else if (cnt == SHW'(XLEN-1)) begin
      state_nxt = IDLE;
      load = 1'b1;
      load_res = acc_nxt;
      load_ill = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // The final (XLEN-th) partial product is folded straight into the output load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (mul_start) begin
      cnt <= '0;
      acc <= '0;
      mcand <= src_a;
      mplier <= src_b;
    end else if (state == MUL_BUSY) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end
`else
  assign in_ready = !out_valid || out_ready;
  assign load = in_valid && in_ready;
  assign load_res = alu_res;
  assign load_ill = alu_ill;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result <= '0;
      zero <= 1'b1;
      illegal <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result <= load_res;
      zero <= load_res == '0;
      illegal <= load_ill;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed checks of alu_exec_unit (default XLEN=32), MUL paths follow ALU_MUL_EN
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] alu_ctrl = 4'h0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] result;
  logic zero;
  logic illegal;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [10] = '{
    '{4'h1, 32'd5,        32'd7,        32'hFFFF_FFFE},
    '{4'h7, 32'h8000_0000, 32'd4,        32'hF800_0000},
    '{4'h9, 32'd1,        32'hFFFF_FFFF, 32'd1},
    '{4'h0, 32'hFFFF_FFFF, 32'd1,        32'd0},
    '{4'h5, 32'd1,        32'h0000_003F, 32'h8000_0000},
    '{4'h6, 32'h8000_0000, 32'd4,        32'h0800_0000},
    '{4'h2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034},
    '{4'h3, 32'hA000_0001, 32'h0500_0010, 32'hA500_0011},
    '{4'h8, 32'hFFFF_FFFF, 32'd1,        32'd1},
    '{4'h9, 32'hFFFF_FFFF, 32'd1,        32'd0}
  };

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = c;
    src_a = a;
    src_b = b;
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h zero=%b illegal=%b, want 0 0 1 0", out_valid, result, zero, illegal);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'h0, 32'd1, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd3) begin
      errors++;
      $display("FAIL pre_reset_add: valid=%b result=%h want 1 00000003", out_valid, result);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: valid=%b result=%h zero=%b illegal=%b, want 0 0 1 0", out_valid, result, zero, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midstream_release_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].c, vecs[i].a, vecs[i].b);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== vecs[i].e || zero !== (vecs[i].e == 32'd0) || illegal !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d] code %h: valid=%b result=%h zero=%b illegal=%b, want 1 %h %b 0",
                 i, vecs[i].c, out_valid, result, zero, illegal, vecs[i].e, vecs[i].e == 32'd0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input string tag);
`ifdef ALU_MUL_EN
    int n;
    out_ready = 1'b1;
    drive(4'hA, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    src_a = 32'h1234_5678;
    src_b = 32'h0;
    n = 0;
    while (!out_valid && n < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_in_ready: got %b want 0 at edge %0d", tag, in_ready, n);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 32 || out_valid !== 1'b1 || result !== e || illegal !== 1'b0) begin
      errors++;
      $display("FAIL %s: edges=%0d valid=%b result=%h illegal=%b, want 32 1 %h 0", tag, n, out_valid, result, illegal, e);
    end
    @(negedge clk);
`else
    out_ready = 1'b1;
    drive(4'hA, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL %s_nomul: valid=%b result=%h zero=%b illegal=%b, want 1 0 1 1 (expected %h unused)", tag, out_valid, result, zero, illegal, e);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_mul;
    run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul_neg1x3");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(4'h0, 32'd2, 32'd2);
    @(negedge clk);
    drive(4'h3, 32'd1, 32'd8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h in_ready=%b, want 1 00000004 0", i, out_valid, result, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd9) begin
      errors++;
      $display("FAIL bp_same_cycle_accept: valid=%b result=%h want 1 00000009", out_valid, result);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    drive(4'hD, 32'd5, 32'd5);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_1101: valid=%b result=%h zero=%b illegal=%b, want 1 0 1 1", out_valid, result, zero, illegal);
    end
    drive(4'h4, 32'hF0, 32'h0F);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFF || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear_xor: valid=%b result=%h zero=%b illegal=%b, want 1 000000ff 0 0", out_valid, result, zero, illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_mul_reset;
`ifdef ALU_MUL_EN
    int seen;
    out_ready = 1'b1;
    drive(4'hA, 32'd6, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_abort_reset: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mul_abort_no_result: out_valid seen %0d cycles want 0", seen);
    end
`endif
    run_mul(32'd6, 32'd7, 32'd42, "mul_6x7");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_illegal();
    test_mul_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
